jt89x: RTL
==========

# jt89x

Parametrised successor to the SN76489 PSG core: three 10-bit tone channels plus one noise channel, programmed through the standard latch/data byte protocol. Adds a configurable noise LFSR (SMS 16-bit or SN76489 15-bit), Game Gear stereo panning, a modelled write-busy `ready`, and a selectable output width. Sits between the CPU I/O decoder and the audio mixer/DAC in the SMS/GG system.

## Interface
- `LFSR_W`, 16, noise shift-register width (15 or 16)
- `LFSR_TAP`, 16'h0009, white-noise feedback tap mask (XOR of masked bits)
- `DIV`, 16, `clk_en` pulses per tone tick (power of 2, 4..64)
- `READY_CYC`, 32, `clk_en` pulses `ready` stays low after a write (0: `ready` always 1)
- `OUT_W`, 11, output sample width (≥11)
- `clk` in 1 system clock
- `rst` in 1 reset; **one clock, reset asynchronous, active-high**
- `clk_en` in 1 PSG clock enable (3.58 MHz equivalent)
- `wr_n` in 1 PSG write strobe, active low; falling edge commits
- `din` in 8 PSG write byte
- `pan_wr` in 1 one-`clk` strobe; writes `din` to the GG stereo register
- `soundL` out OUT_W signed left sample
- `soundR` out OUT_W signed right sample
- `ready` out 1 high when a new write is accepted

## Operation
- Write decode on the registered falling edge of `wr_n`; writes with `ready`=0 are ignored.
  - `din[7]`=1: latch `reg=din[6:4]`, write the low field.
  - `din[7]`=0: data byte to the latched register; a tone gets `tone[9:4]=din[5:0]`; volume/noise get `din[3:0]` / `din[2:0]`.
- Registers: tone0..2 (10b), vol0..3 (4b attenuation, 2 dB/step, 15 = silent), ctrl3 (3b: bit2 white/periodic, [1:0] rate).
- Any write to ctrl3 reloads the LFSR with `1<<(LFSR_W-1)`.
- Tick: `cen_t` asserts every DIV-th `clk_en`.
- Tone channel, on `cen_t`:
  - Counter decrements. At 0 it reloads `tone` and toggles the output flip-flop.
  - `tone` 0 or 1 holds the output high (DC).
- Noise clock source: rate 0/1/2 → a toggle every 16/32/64 ticks; rate 3 → tone2 flip-flop toggles.
- Noise shifts on each rising edge of its clock.
  - White: `fb = ^(lfsr & LFSR_TAP)`.
  - Periodic: `fb = lfsr[0]`.
  - Shift right, `fb` enters the MSB; output = `lfsr[0]`.
  - An all-zero state is forced to `1<<(LFSR_W-1)`.
- Amplitude per channel: `amp = VOL_TBL[vol]` (8b, 0 at 15). The channel contributes `+amp` when high and `-amp` when low.
- Pan register `pan[7:4]` enables noise, ch2, ch1, ch0 on the left; `pan[3:0]` the same on the right.
- Each side is the sign-extended sum of its enabled contributions.

## Timing
- Reset values:
  - `vol*`=15, `tone*`=0, `ctrl3`=3'b100, latch=0.
  - LFSR=`1<<(LFSR_W-1)`, `pan`=8'hFF, prescaler and counters=0.
  - `soundL`=`soundR`=0, `ready`=1.
- Register write effective 2 `clk` after the `wr_n` fall (sync + commit). `pan_wr` effective the next `clk`.
- `soundL`/`soundR` registered and updated only on `cen_t`; one tick of latency after a register change.
- `ready` drops the `clk` after the commit and rises after READY_CYC `clk_en` pulses.
- Simultaneous `pan_wr` and `wr_n` commit: both apply.
- Tone counter reload and register write in the same cycle: the new value is used on the next reload; no glitch to the running count.
- LFSR reload and noise shift in the same cycle: the reload wins.
- `rst` mid-operation: immediate return to reset values; no pending write survives.

## Structure
- Package `jt89x_pkg`:
  - `VOL_TBL[16]`: 255,203,161,128,102,81,64,51,40,32,26,20,16,13,10,0.
  - Register index constants (TONE0..VOL3).
  - Noise rate constants.
- Sub-module `jt89x_tone_gen`: counter plus flip-flop with `tone`/`cen_t` in and `out`/`toggle` out, instantiated 3×.
- Noise, decode, pan and mixer stay in the top module.

## Test plan
- Reset, then idle 1000 `clk_en` → `soundL`=`soundR`=0, `ready`=1.
- Write 0x8E, 0x0F, 0x90 (tone0=0x0FE, vol0=0) → ch0 period 2·254·16 `clk_en`; samples alternate +255/−255 on both sides.
- Write 0xE4, vol3=0 → white noise. With LFSR_W=16 the first 8 outputs from reload are 0,0,0,0,0,0,0,0 and the state after 16 shifts matches the golden model. A second 0xE4 mid-stream restarts the sequence.
- `pan_wr` with `din`=8'h10 while ch0 is active → `soundL` shows ±255 and `soundR`=0.
- Write 0x81 then 0x00 (tone0=1) → ch0 held at +amp, no toggles over 10000 ticks.
- READY_CYC=32: write during the busy window is ignored (register unchanged); the write accepted after `ready` rises takes effect.

Source files
------------

// File: rtl/jt89x_pkg.sv
// Shared constants for the jt89x PSG: attenuation table, register map, noise rates.
package jt89x_pkg;

    // 2 dB per step, 15 is silent
    localparam logic [7:0] VOL_TBL [16] = '{
        8'd255, 8'd203, 8'd161, 8'd128, 8'd102, 8'd81, 8'd64, 8'd51,
        8'd40,  8'd32,  8'd26,  8'd20,  8'd16,  8'd13, 8'd10, 8'd0
    };

    localparam logic [2:0] TONE0 = 3'd0;
    localparam logic [2:0] VOL0  = 3'd1;
    localparam logic [2:0] TONE1 = 3'd2;
    localparam logic [2:0] VOL1  = 3'd3;
    localparam logic [2:0] TONE2 = 3'd4;
    localparam logic [2:0] VOL2  = 3'd5;
    localparam logic [2:0] NOISE = 3'd6;
    localparam logic [2:0] VOL3  = 3'd7;

    localparam logic [2:0] TONE_REG [3] = '{TONE0, TONE1, TONE2};
    localparam logic [2:0] VOL_REG  [4] = '{VOL0, VOL1, VOL2, VOL3};

    typedef enum logic [1:0] {
        NRate16    = 2'd0,
        NRate32    = 2'd1,
        NRate64    = 2'd2,
        NRateTone2 = 2'd3
    } nrate_e;

    // Signed (two's complement, 11b) contribution of one channel
    function automatic logic [10:0] contrib(input logic hi, input logic [3:0] vol);
        logic [10:0] a;
        a = {3'b000, VOL_TBL[vol]};
        return hi ? a : (~a + 11'd1);
    endfunction

endpackage

// File: rtl/jt89x_if.sv
// CPU-side write bus of the PSG: byte writes, stereo register strobe, busy flag.
interface jt89x_if;
    logic       wr_n;
    logic [7:0] din;
    logic       pan_wr;
    logic       ready;

    modport master (output wr_n, output din, output pan_wr, input ready);
    modport slave  (input wr_n, input din, input pan_wr, output ready);
endinterface

// File: rtl/jt89x_tone_gen.sv
// One square-wave tone channel: down-counter reloaded from the period register.
module jt89x_tone_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen_t,
    input  logic [9:0] tone,
    output logic       out,
    output logic       toggle
);
    logic [9:0] cnt_q;
    logic       dc;

    // Periods 0 and 1 park the output high instead of oscillating
    assign dc     = (tone[9:1] == 9'd0);
    assign toggle = cen_t & ~dc & (cnt_q <= 10'd1);

    // Counter and output flip-flop; period is only sampled at reload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 10'd0;
            out   <= 1'b0;
        end else if (cen_t) begin
            if (dc) begin
                cnt_q <= 10'd0;
                out   <= 1'b1;
            end else if (cnt_q <= 10'd1) begin
                cnt_q <= tone;
                out   <= ~out;
            end else begin
                cnt_q <= cnt_q - 10'd1;
            end
        end
    end

endmodule

// File: rtl/jt89x.sv
// jt89x PSG top: write decode, busy timer, prescaler, noise LFSR, pan and stereo mixer.
module jt89x
    import jt89x_pkg::*;
#(
    parameter int unsigned LFSR_W    = 16,
    parameter logic [15:0] LFSR_TAP  = 16'h0009,
    parameter int unsigned DIV       = 16,
    parameter int unsigned READY_CYC = 32,
    parameter int unsigned OUT_W     = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    jt89x_if.slave                  bus,
    output logic signed [OUT_W-1:0] soundL,
    output logic signed [OUT_W-1:0] soundR
);
    localparam int unsigned       PW        = $clog2(DIV);
    localparam logic [LFSR_W-1:0] LFSR_INIT = {1'b1, {(LFSR_W-1){1'b0}}};
    localparam logic [LFSR_W-1:0] TAP       = LFSR_TAP[LFSR_W-1:0];

    logic              wr_n_s, wr_n_d, wr_acc;
    logic [7:0]        din_s;
    logic [2:0]        reg_sel, latch_q, ctrl_q;
    logic [15:0]       busy_q;
    logic [9:0]        tone_q [3];
    logic [3:0]        vol_q [4];
    logic [7:0]        pan_q;
    logic [PW-1:0]     presc_q;
    logic              cen_t;
    logic [2:0]        tone_out, tone_tog;
    logic              unused_tog;
    nrate_e            rate;
    logic [5:0]        ncnt_q, n_lim;
    logic              nclk_q, n_wrap, n_shift, fb, lfsr_reload;
    logic [LFSR_W-1:0] lfsr_q, lfsr_nxt;
    logic [3:0]        ch_hi;
    logic [10:0]       c;
    logic signed [10:0] sum_l, sum_r;

    assign wr_acc      = wr_n_d & ~wr_n_s & bus.ready;
    assign reg_sel     = din_s[7] ? din_s[6:4] : latch_q;
    assign bus.ready   = (busy_q == 16'd0);
    assign lfsr_reload = wr_acc & (reg_sel == NOISE);
    assign rate        = nrate_e'(ctrl_q[1:0]);
    assign cen_t       = clk_en & (&presc_q);
    // Only tone2's toggle drives the noise clock
    assign unused_tog  = ^tone_tog[1:0];

    // Synchronise wr_n; stages reset low so a strobe held through reset never commits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_n_s <= 1'b0;
            wr_n_d <= 1'b0;
            din_s  <= 8'd0;
        end else begin
            wr_n_s <= bus.wr_n;
            wr_n_d <= wr_n_s;
            din_s  <= bus.din;
        end
    end

    // Busy timer: counts clk_en pulses after each accepted write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 16'd0;
        end else if (wr_acc) begin
            busy_q <= 16'(READY_CYC);
        end else if (clk_en && busy_q != 16'd0) begin
            busy_q <= busy_q - 16'd1;
        end
    end

    // Register file: latch byte writes the low field, data byte the high/whole field
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_q <= 3'd0;
            ctrl_q  <= 3'b100;
            for (int i = 0; i < 3; i++) tone_q[i] <= 10'd0;
            for (int i = 0; i < 4; i++) vol_q[i] <= 4'hF;
        end else if (wr_acc) begin
            if (din_s[7]) latch_q <= din_s[6:4];
            for (int i = 0; i < 3; i++) begin
                if (reg_sel == TONE_REG[i]) begin
                    if (din_s[7]) tone_q[i][3:0] <= din_s[3:0];
                    else          tone_q[i][9:4] <= din_s[5:0];
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (reg_sel == VOL_REG[i]) vol_q[i] <= din_s[3:0];
            end
            if (reg_sel == NOISE) ctrl_q <= din_s[2:0];
        end
    end

    // Game Gear stereo register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pan_q <= 8'hFF;
        end else if (bus.pan_wr) begin
            pan_q <= bus.din;
        end
    end

    // Tick prescaler: DIV is a power of two so the counter wraps on its own
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else if (clk_en) begin
            presc_q <= presc_q + PW'(1);
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_tone
        jt89x_tone_gen u_tone (
            .clk    (clk),
            .rst    (rst),
            .cen_t  (cen_t),
            .tone   (tone_q[i]),
            .out    (tone_out[i]),
            .toggle (tone_tog[i])
        );
    end

    // Noise clock selection and next LFSR state
    always_comb begin
        n_lim    = 6'd63;
        n_shift  = 1'b0;
        fb       = 1'b0;
        lfsr_nxt = lfsr_q;
        case (rate)
            NRate16: n_lim = 6'd15;
            NRate32: n_lim = 6'd31;
            default: n_lim = 6'd63;
        endcase
        n_wrap = (ncnt_q >= n_lim);
        if (rate == NRateTone2) n_shift = tone_tog[2] & ~tone_out[2];
        else                    n_shift = cen_t & n_wrap & ~nclk_q;
        fb       = ctrl_q[2] ? ^(lfsr_q & TAP) : lfsr_q[0];
        lfsr_nxt = {fb, lfsr_q[LFSR_W-1:1]};
        if (lfsr_nxt == '0) lfsr_nxt = LFSR_INIT;
    end

    // Noise divider flip-flop; shifts happen on its rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ncnt_q <= 6'd0;
            nclk_q <= 1'b0;
        end else if (cen_t) begin
            if (n_wrap) begin
                ncnt_q <= 6'd0;
                nclk_q <= ~nclk_q;
            end else begin
                ncnt_q <= ncnt_q + 6'd1;
            end
        end
    end

    // LFSR: a control write reload beats a coincident shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_INIT;
        end else if (lfsr_reload) begin
            lfsr_q <= LFSR_INIT;
        end else if (n_shift) begin
            lfsr_q <= lfsr_nxt;
        end
    end

    // Stereo mix of +/-amp contributions gated by the pan bits
    always_comb begin
        ch_hi = {lfsr_q[0], tone_out};
        c     = 11'd0;
        sum_l = 11'sd0;
        sum_r = 11'sd0;
        for (int i = 0; i < 4; i++) begin
            c = contrib(ch_hi[i], vol_q[i]);
            if (pan_q[4+i]) sum_l = sum_l + c;
            if (pan_q[i])   sum_r = sum_r + c;
        end
    end

    // Output samples refresh once per tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            soundL <= '0;
            soundR <= '0;
        end else if (cen_t) begin
            soundL <= OUT_W'(sum_l);
            soundR <= OUT_W'(sum_r);
        end
    end

endmodule
